rr_prio_arbiter: RTL
====================

Name: rr_prio_arbiter

Overview:
- Arbitrates one shared resource among NREQ requesters, built around the 4-input priority-encoding function (one-hot/encoded grant plus valid flag).
- Two modes, selected by rr_en:
  - Fixed priority: highest index wins, the same as the priority encoder.
  - Rotating (round-robin) priority: prevents starvation.
- Grants are held until the owner releases or a hold-timeout fires.
- Sits between requesting datapath blocks and the shared resource.

Parameters:
- NREQ, 4, number of requesters (implementation and bench target 4).
- IDXW, 2, width of the encoded grant index (clog2(NREQ)).
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held before forced release (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rr_en  input  1  1 = rotating priority; 0 = fixed priority, highest index wins. Sampled only in IDLE.
- req  input  NREQ  request vector; a requester holds its bit high while it needs the resource.
- gnt  output  NREQ  one-hot grant, registered.
- gnt_idx  output  IDXW  encoded index of the granted requester; 0 when gnt_vld=0.
- gnt_vld  output  1  1 when any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - ptr=0, hold_cnt=0.
  - Reset asserted mid-grant drops gnt immediately, with no release cycle.
- State IDLE:
  - If req==0: stay; outputs 0.
  - Otherwise pick winner w:
    - rr_en=0: w = highest set index of req.
    - rr_en=1: first set bit scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - Next edge: state=GRANT, gnt=1<<w, gnt_idx=w, gnt_vld=1, hold_cnt=1.
  - Latency is 1 cycle from req seen in IDLE to gnt.
- State GRANT (owner g):
  - Release when req[g]=0 at a rising edge: next state=GAP, gnt=0, ptr=(g+1) mod NREQ.
  - Release when req[g]=1 and hold_cnt==MAX_HOLD: same as above, plus timeout=1 for that single GAP cycle.
  - Otherwise: hold_cnt increments (saturating width ≥ clog2(MAX_HOLD+1)); gnt unchanged.
  - Requests from other indices never pre-empt a grant, including higher-priority ones.
- State GAP:
  - Exactly one dead cycle; all grant outputs 0. timeout as above, otherwise 0.
  - Next state IDLE unconditionally.
  - Minimum spacing between consecutive grants is therefore 2 idle-edge cycles (GAP, then IDLE arbitration).
- ptr update:
  - Updates on every release, in both modes.
  - Only affects selection when rr_en=1.
  - Wraps from NREQ-1 to 0.
- Simultaneous events:
  - Owner dropping req in the same cycle hold_cnt reaches MAX_HOLD counts as a normal release (timeout=0).
  - New requests arriving during GRANT/GAP are considered only in IDLE.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld == |gnt.
  - gnt_idx matches gnt.
  - No X on outputs after reset.

Test Plan:
- Reset with req=4'b1111, rr_en=0 held -> all outputs 0; release rst_n -> after 1 edge gnt=4'b1000, gnt_idx=2'b11, gnt_vld=1.
- Fixed mode, req=4'b0110 -> gnt=4'b0100, idx=2; drop req[2] -> one GAP cycle (gnt=0), then IDLE, then gnt=4'b0010, idx=1.
- Rotating mode from reset (ptr=0), req=4'b1111 held, each owner drops its bit for one cycle after being granted -> grant order idx 0,1,2,3,0 with a GAP between each.
- Timeout: MAX_HOLD=8, rr_en=1, req=4'b0001 held -> gnt=4'b0001 for exactly 8 cycles, timeout=1 for one cycle with gnt=0, then regrant idx 0 (sole requester).
- Timeout fairness: req=4'b0011 held, rr_en=1 -> idx0 held 8 cycles, timeout pulse, next grant idx1.
- Mid-grant reset: assert rst_n=0 during GRANT (gnt=4'b0100) -> gnt=0 asynchronously before next edge; after release, ptr=0 and rotating mode grants lowest set index first.

Source files
------------

// File: rtl/rr_prio_arbiter.sv
// Single-resource arbiter: fixed (highest index wins) or round-robin selection,
// grants held until the owner releases or MAX_HOLD cycles elapse, then one dead cycle.
module rr_prio_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDXW     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rr_en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            timeout
);

    localparam int CNTW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IDXW-1:0] owner, owner_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [CNTW-1:0] hold_cnt, hold_cnt_nxt;
    logic            to_flag, to_flag_nxt;

    function automatic logic [IDXW-1:0] pick_fixed(input logic [NREQ-1:0] r);
        logic [IDXW-1:0] k;
        pick_fixed = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IDXW'(i);
            if (r[k]) pick_fixed = k;
        end
    endfunction

    // First requester found scanning upward from p, wrapping around.
    function automatic logic [IDXW-1:0] pick_rr(input logic [NREQ-1:0] r,
                                                input logic [IDXW-1:0] p);
        logic found;
        int   idx;
        pick_rr = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!found && r[idx[IDXW-1:0]]) begin
                pick_rr = idx[IDXW-1:0];
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] g);
        next_ptr = (g == IDXW'(NREQ - 1)) ? '0 : g + IDXW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            to_flag  <= to_flag_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        to_flag_nxt  = to_flag;
        case (state)
            IDLE: begin
                to_flag_nxt = 1'b0;
                if (|req) begin
                    state_nxt    = GRANT;
                    owner_nxt    = rr_en ? pick_rr(req, ptr) : pick_fixed(req);
                    hold_cnt_nxt = CNTW'(1);
                end
            end
            GRANT: begin
                // An owner dropping its request wins over a simultaneous timeout.
                if (!req[owner]) begin
                    state_nxt    = GAP;
                    ptr_nxt      = next_ptr(owner);
                    hold_cnt_nxt = '0;
                    to_flag_nxt  = 1'b0;
                end else if (hold_cnt == CNTW'(MAX_HOLD)) begin
                    state_nxt    = GAP;
                    ptr_nxt      = next_ptr(owner);
                    hold_cnt_nxt = '0;
                    to_flag_nxt  = 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_cnt_nxt = hold_cnt + CNTW'(1);
                end
            end
            GAP: begin
                state_nxt   = IDLE;
                to_flag_nxt = 1'b0;
            end
            default: begin
                state_nxt   = IDLE;
                to_flag_nxt = 1'b0;
            end
        endcase
    end

    // Outputs depend only on flops, so they are glitch-free and clear with reset.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        timeout = 1'b0;
        case (state)
            GRANT: begin
                gnt     = NREQ'(1) << owner;
                gnt_idx = owner;
                gnt_vld = 1'b1;
            end
            GAP:     timeout = to_flag;
            default: ;
        endcase
    end

endmodule
